noc_inject_arb: RTL
===================

Name: noc_inject_arb

Overview:
Packet-atomic round-robin arbiter that shares one router local injection port (idata_4/ivalid_4/ivch_4/ordy_4, exposed at the NoC top as nX_*_p0) among NREQ on-tile requesters.
- Grants whole wormhole packets (head..tail) and respects per-VC ready from the router.
- Drives the port from a one-entry output register.
- Tracks protocol errors and a count of sent packets.
- One instance per router node, between tile masters and the NoC top.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 35, flit width; [DATA_W-1:DATA_W-2] = flit type, rest = payload
VCH_W, 1, VC id width
NVC, 2, number of VCs (= 2**VCH_W)
CNT_W, 16, width of packet counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req_data  in  NREQ*DATA_W  requester flits, requester i at [i*DATA_W +: DATA_W]
req_valid  in  NREQ  flit valid per requester
req_vch  in  NREQ*VCH_W  requested VC (sampled on head/single only)
req_rdy  out  NREQ  flit accepted this cycle when req_valid&req_rdy
odata  out  DATA_W  to router idata_p0
ovalid  out  1  to router ivalid_p0
ovch  out  VCH_W  to router ivch_p0
ordy  in  NVC  router per-VC ready (ordy_p0)
busy  out  1  packet lock held or output register full
err_proto  out  1  sticky protocol error
pkt_cnt  out  CNT_W  packets fully accepted (tail/single), wraps

Behaviour:
- Flit type: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- Reset: all outputs 0, rr pointer = 0, lock cleared, output register empty. A reset mid-packet abandons the packet; the router side is reset concurrently.
- Output register (oreg):
  - ovalid = oreg full; odata/ovch come from oreg.
  - Transfer = ovalid & ordy[ovch].
  - can_load = !ovalid | transfer. Back-to-back flits sustain 1 flit/cycle.
- States:
  - IDLE: no lock.
    - Eligible i: req_valid[i], type head or single, ordy[req_vch[i]]=1.
    - Round-robin pick starting at ptr; with can_load, grant winner g: req_rdy[g]=1, load oreg with data and vch.
    - Head -> LOCKED(g, vch). Single -> stay IDLE, pkt_cnt+1.
    - ptr <= g+1 mod NREQ on every grant.
  - LOCKED(g, v): only g is served; req_rdy[g] = can_load.
    - ovch uses latched v; req_vch ignored.
    - Body -> stay. Tail -> IDLE, pkt_cnt+1.
    - Head/single arriving while locked: err_proto=1, flit consumed and dropped, lock kept.
  - Other requesters: req_rdy=0 while LOCKED.
- Non-head flit (body/tail) valid at a requester in IDLE:
  - Not eligible; consumed with req_rdy=1 only when that requester is the RR pick among non-eligible-garbage and no eligible head exists; dropped; err_proto=1.
  - Simplification: garbage flits are dropped one per cycle, lowest index first, only when no eligible head exists.
- Head whose VC ordy is low: skipped (no HOL block); other VCs proceed.
- ordy deasserting mid-packet: oreg holds, req_rdy[g]=0, lock held.
- Latency: accepted flit appears on ovalid the next cycle. Max throughput 1 flit/cycle.
- busy = lock | ovalid. err_proto clears only on rst.
- pkt_cnt wraps 2**CNT_W-1 -> 0.

Decomposition:
- Shared package/header noc_pkg: flit type constants (FT_HEAD/BODY/TAIL/SINGLE), DATA_W, VCH_W, NVC, and a type-field extract macro/function.
- One sub-module, rr_arb (NREQ request bits + ptr -> one-hot grant + index), reusable by router-side allocators.
- FSM, output register and counters stay in the top module.

Test Plan:
1. Single-flit: req0 single payload 0x1, vch 0, ordy=2'b11 -> req_rdy[0] in cycle 0; ovalid=1, odata type 11, ovch=0 in cycle 1; pkt_cnt=1.
2. Fairness: req0..3 each send 4-flit packets continuously, ordy=11 -> packets granted in order 0,1,2,3,0...; no flit interleaving; 16 flits in 16 cycles; pkt_cnt=4 after first round.
3. Per-VC skip: req0 head vch1, req1 head vch0, ordy=2'b01 -> req1 granted first; req0 held; ordy=11 later -> req0 granted.
4. Backpressure mid-packet: 3-flit packet; ordy[v] low for 5 cycles after head -> body held in oreg, req_rdy=0, no other grant, resumes 1 flit/cycle.
5. Protocol errors: body flit on idle req2 with no heads pending -> dropped, err_proto=1. Head from g while LOCKED -> dropped, lock kept, tail still closes the packet.
6. Reset mid-packet: rst after head -> next cycle ovalid=0, busy=0, pkt_cnt=0, err_proto=0, ptr=0; a new head from req3 is granted normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, default port widths and a
// helper that decodes the type field from the top two bits of a flit.
package noc_pkg;

  localparam int DATA_W = 35;
  localparam int VCH_W  = 1;
  localparam int NVC    = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [1:0] hdr);
    return flit_type_e'(hdr);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) wins; returns one-hot grant, its index and an any-request flag.
module rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arb.sv
// Packet-atomic round-robin arbiter sharing one router injection port among
// NREQ tile requesters, with a one-entry output register toward the router.
//
//   state  | meaning
//   IDLE   | no packet lock; grant head/single flits round-robin
//   LOCKED | serving requester lock_g_q on VC lock_v_q until its tail
module noc_inject_arb
  import noc_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int VCH_W  = noc_pkg::VCH_W,
  parameter int NVC    = noc_pkg::NVC,
  parameter int CNT_W  = noc_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*VCH_W-1:0]  req_vch,
  output logic [NREQ-1:0]        req_rdy,
  output logic [DATA_W-1:0]      odata,
  output logic                   ovalid,
  output logic [VCH_W-1:0]       ovch,
  input  logic [NVC-1:0]         ordy,
  output logic                   busy,
  output logic                   err_proto,
  output logic [CNT_W-1:0]       pkt_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, lock_g_q, lock_g_d, win_idx, garb_idx;
  logic [VCH_W-1:0]  lock_v_q, lock_v_d;
  logic [DATA_W-1:0] odata_q, load_data;
  logic [VCH_W-1:0]  ovch_q, load_vch;
  logic              ovalid_q, err_q;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic              load, err_set, cnt_inc, transfer, can_load, win_any;
  logic [NREQ-1:0]   elig, garbage, win_gnt;
  flit_type_e        ft [NREQ];
  logic [VCH_W-1:0]  vch [NREQ];

  assign transfer = ovalid_q & ordy[ovch_q];
  assign can_load = !ovalid_q | transfer;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ft[i]      = flit_type(req_data[i*DATA_W + DATA_W - 2 +: 2]);
      vch[i]     = req_vch[i*VCH_W +: VCH_W];
      elig[i]    = req_valid[i] && (ft[i] == FT_HEAD || ft[i] == FT_SINGLE) && ordy[vch[i]];
      garbage[i] = req_valid[i] && (ft[i] == FT_BODY || ft[i] == FT_TAIL);
    end
  end

  // Stray body/tail flits are flushed lowest index first.
  always_comb begin
    garb_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (garbage[i]) garb_idx = PTR_W'(i);
    end
  end

  rr_arb #(.N(NREQ), .IDX_W(PTR_W)) u_rr_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_g_d  = lock_g_q;
    lock_v_d  = lock_v_q;
    req_rdy   = '0;
    load      = 1'b0;
    load_data = '0;
    load_vch  = '0;
    err_set   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          if (can_load) begin
            req_rdy   = win_gnt;
            load      = 1'b1;
            load_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
            load_vch  = vch[win_idx];
            ptr_d     = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            if (ft[win_idx] == FT_HEAD) begin
              state_d  = LOCKED;
              lock_g_d = win_idx;
              lock_v_d = vch[win_idx];
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end else if (|garbage) begin
          req_rdy[garb_idx] = 1'b1;
          err_set           = 1'b1;
        end
      end
      LOCKED: begin
        req_rdy[lock_g_q] = can_load;
        if (req_valid[lock_g_q] && can_load) begin
          case (ft[lock_g_q])
            FT_BODY: begin
              load      = 1'b1;
              load_data = req_data[int'(lock_g_q)*DATA_W +: DATA_W];
              load_vch  = lock_v_q;
            end
            FT_TAIL: begin
              load      = 1'b1;
              load_data = req_data[int'(lock_g_q)*DATA_W +: DATA_W];
              load_vch  = lock_v_q;
              cnt_inc   = 1'b1;
              state_d   = IDLE;
            end
            default: err_set = 1'b1;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_g_q  <= '0;
      lock_v_q  <= '0;
      odata_q   <= '0;
      ovch_q    <= '0;
      ovalid_q  <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lock_g_q <= lock_g_d;
      lock_v_q <= lock_v_d;
      if (load) begin
        ovalid_q <= 1'b1;
        odata_q  <= load_data;
        ovch_q   <= load_vch;
      end else if (transfer) begin
        ovalid_q <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (cnt_inc) pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ovch      = ovch_q;
  assign busy      = (state_q == LOCKED) | ovalid_q;
  assign err_proto = err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule
